// File: rtl/capture_mem_pkg.sv
// Shared definitions for the banked capture memory: bank power states,
// macro control levels and the bank-index width helper.
package capture_mem_pkg;

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_SLEEP  = 2'd1,
        ST_WAKE   = 2'd2
    } bank_state_e;

    // Macro strobes are active low.
    localparam logic CEB_ON  = 1'b0;
    localparam logic CEB_OFF = 1'b1;
    localparam logic WEB_WR  = 1'b0;
    localparam logic WEB_RD  = 1'b1;

    function automatic int bank_idx_w(input int banks);
        if (banks > 1) begin
            return $clog2(banks);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/sram_sp_macro.sv
// Behavioural wrapper of one single-port SRAM macro: synchronous access,
// registered Q that holds between reads, contents kept through sleep.
module sram_sp_macro
    import capture_mem_pkg::*;
#(
    parameter int AW = 15,
    parameter int DW = 9
) (
    input  logic          CLK,
    input  logic          SLP,
    input  logic          SD,
    input  logic          CEB,
    input  logic          WEB,
    input  logic [AW-1:0] A,
    input  logic [DW-1:0] D,
    output logic [DW-1:0] Q
);

    logic [DW-1:0] mem_r [2**AW];
    logic          en_s;

    assign en_s = (CEB == CEB_ON) && !SLP && !SD;

    // Array write or registered read on an enabled cycle.
    always_ff @(posedge CLK) begin
        if (en_s) begin
            if (WEB == WEB_WR) begin
                mem_r[A] <= D;
            end else begin
                Q <= mem_r[A];
            end
        end
    end

endmodule

// File: rtl/capture_mem_bank.sv
// Banked capture memory: per-bank sleep FSMs, write-priority arbitration
// between one write and one read port, and a two-cycle read pipeline.
module capture_mem_bank
    import capture_mem_pkg::*;
#(
    parameter int   BANK_AW    = 15,
    parameter int   DATA_WIDTH = 9,
    parameter int   BANKS      = 4,
    parameter int   SLEEP_IDLE = 1024,
    parameter int   WAKE_CYC   = 4,
    localparam int  BW         = bank_idx_w(BANKS),
    localparam int  ADDR_WIDTH = BANK_AW + BW
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  sleep_en,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_gnt,
    output logic                  rd_dvalid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [BANKS-1:0]      bank_sleep
);

    localparam int IW = $clog2(SLEEP_IDLE + 1);
    localparam int WW = $clog2(WAKE_CYC + 1);
    localparam logic [IW-1:0] IDLE_MAX  = IW'(SLEEP_IDLE);
    localparam logic [WW-1:0] WAKE_LAST = WW'(WAKE_CYC - 1);

    logic [BW-1:0]         wr_bank_s;
    logic [BW-1:0]         rd_bank_s;
    logic [BANKS-1:0]      active_s;
    logic                  wr_acc_s;
    logic                  rd_gnt_s;
    logic [DATA_WIDTH-1:0] q_s [BANKS];
    logic                  rd_v1_r;
    logic [BW-1:0]         rd_bank1_r;
    logic                  rd_dvalid_r;
    logic [DATA_WIDTH-1:0] rd_data_r;

    assign wr_bank_s = wr_addr[ADDR_WIDTH-1:BANK_AW];
    assign rd_bank_s = rd_addr[ADDR_WIDTH-1:BANK_AW];

    // Write wins a same-bank collision; the read simply retries next cycle.
    assign wr_acc_s = wr_en & active_s[wr_bank_s];
    assign rd_gnt_s = rd_en & active_s[rd_bank_s] & ~(wr_acc_s & (wr_bank_s == rd_bank_s));

    assign wr_ready  = wr_acc_s;
    assign rd_gnt    = rd_gnt_s;
    assign rd_dvalid = rd_dvalid_r;
    assign rd_data   = rd_data_r;

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        localparam logic [BW-1:0] BID = BW'(b);

        bank_state_e          state_r;
        bank_state_e          state_nx_s;
        logic [IW-1:0]        idle_r;
        logic [WW-1:0]        wake_r;
        logic                 req_s;
        logic                 wr_hit_s;
        logic                 rd_hit_s;
        logic                 ceb_s;
        logic                 web_s;
        logic [BANK_AW-1:0]   a_s;

        // A pending request counts as activity even while it is stalled.
        assign req_s    = (wr_en && (wr_bank_s == BID)) || (rd_en && (rd_bank_s == BID));
        assign wr_hit_s = wr_acc_s && (wr_bank_s == BID);
        assign rd_hit_s = rd_gnt_s && (rd_bank_s == BID);

        // Bank power-state register.
        always_ff @(posedge CLK or negedge RSTN) begin
            if (!RSTN) begin
                state_r <= ST_ACTIVE;
            end else begin
                state_r <= state_nx_s;
            end
        end

        // Idle counter (ACTIVE only) and wake-delay counter.
        always_ff @(posedge CLK or negedge RSTN) begin
            if (!RSTN) begin
                idle_r <= {IW{1'b0}};
                wake_r <= {WW{1'b0}};
            end else begin
                if ((state_r != ST_ACTIVE) || req_s || !sleep_en) begin
                    idle_r <= {IW{1'b0}};
                end else if (idle_r != IDLE_MAX) begin
                    idle_r <= idle_r + IW'(1);
                end
                if (state_r == ST_WAKE) begin
                    wake_r <= wake_r + WW'(1);
                end else begin
                    wake_r <= {WW{1'b0}};
                end
            end
        end

        // Power-state transitions.
        always_comb begin
            state_nx_s = state_r;
            case (state_r)
                ST_ACTIVE: begin
                    if (sleep_en && !req_s && (idle_r == IDLE_MAX)) begin
                        state_nx_s = ST_SLEEP;
                    end else begin
                        state_nx_s = ST_ACTIVE;
                    end
                end
                ST_SLEEP: begin
                    if (req_s || !sleep_en) begin
                        state_nx_s = ST_WAKE;
                    end else begin
                        state_nx_s = ST_SLEEP;
                    end
                end
                ST_WAKE: begin
                    if (wake_r == WAKE_LAST) begin
                        state_nx_s = ST_ACTIVE;
                    end else begin
                        state_nx_s = ST_WAKE;
                    end
                end
                default: state_nx_s = ST_ACTIVE;
            endcase
        end

        // Macro strobe and address selection.
        always_comb begin
            ceb_s = CEB_OFF;
            web_s = WEB_RD;
            a_s   = rd_addr[BANK_AW-1:0];
            if (wr_hit_s) begin
                ceb_s = CEB_ON;
                web_s = WEB_WR;
                a_s   = wr_addr[BANK_AW-1:0];
            end else if (rd_hit_s) begin
                ceb_s = CEB_ON;
            end else begin
                ceb_s = CEB_OFF;
            end
        end

        assign active_s[b]   = (state_r == ST_ACTIVE);
        assign bank_sleep[b] = (state_r == ST_SLEEP);

        sram_sp_macro #(
            .AW (BANK_AW),
            .DW (DATA_WIDTH)
        ) u_macro (
            .CLK (CLK),
            .SLP (state_r != ST_ACTIVE),
            .SD  (1'b0),
            .CEB (ceb_s),
            .WEB (web_s),
            .A   (a_s),
            .D   (wr_data),
            .Q   (q_s[b])
        );
    end

    // Read pipeline: bank index follows the access, data registered a cycle later.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            rd_v1_r     <= 1'b0;
            rd_bank1_r  <= {BW{1'b0}};
            rd_dvalid_r <= 1'b0;
            rd_data_r   <= {DATA_WIDTH{1'b0}};
        end else begin
            rd_v1_r     <= rd_gnt_s;
            rd_bank1_r  <= rd_bank_s;
            rd_dvalid_r <= rd_v1_r;
            if (rd_v1_r) begin
                rd_data_r <= q_s[rd_bank1_r];
            end
        end
    end

endmodule

// File: tb/tb_capture_mem_bank.sv
// Directed self-checking bench for capture_mem_bank (SLEEP_IDLE reduced to 16).
module tb_capture_mem_bank;

    localparam int AW = 17;
    localparam int DW = 9;
    localparam int NB = 4;

    logic          CLK = 1'b0;
    logic          RSTN = 1'b0;
    logic          sleep_en = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ready;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_gnt;
    logic          rd_dvalid;
    logic [DW-1:0] rd_data;
    logic [NB-1:0] bank_sleep;

    int n_tests = 0;
    int n_fail  = 0;

    logic [AW-1:0] b2b_addr [8];
    logic [DW-1:0] b2b_exp  [8];

    capture_mem_bank #(
        .BANK_AW    (15),
        .DATA_WIDTH (DW),
        .BANKS      (NB),
        .SLEEP_IDLE (16),
        .WAKE_CYC   (4)
    ) dut (
        .CLK        (CLK),
        .RSTN       (RSTN),
        .sleep_en   (sleep_en),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_gnt     (rd_gnt),
        .rd_dvalid  (rd_dvalid),
        .rd_data    (rd_data),
        .bank_sleep (bank_sleep)
    );

    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input string tag);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        #1;
        check_val({tag, "_wr_ready"}, 32'(wr_ready), 32'd1);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input logic [DW-1:0] exp, input string tag);
        rd_en   = 1'b1;
        rd_addr = addr;
        #1;
        check_val({tag, "_gnt"}, 32'(rd_gnt), 32'd1);
        tick();
        rd_en = 1'b0;
        #1;
        check_val({tag, "_dv_n1"}, 32'(rd_dvalid), 32'd0);
        tick();
        #1;
        check_val({tag, "_dv_n2"}, 32'(rd_dvalid), 32'd1);
        check_val({tag, "_data"}, 32'(rd_data), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        b2b_addr[0] = 17'h07FFF; b2b_exp[0] = 9'h0AA;
        b2b_addr[1] = 17'h08000; b2b_exp[1] = 9'h155;
        b2b_addr[2] = 17'h00000; b2b_exp[2] = 9'h1A5;
        b2b_addr[3] = 17'h00010; b2b_exp[3] = 9'h033;
        b2b_addr[4] = 17'h00020; b2b_exp[4] = 9'h0C3;
        b2b_addr[5] = 17'h07FFF; b2b_exp[5] = 9'h0AA;
        b2b_addr[6] = 17'h08000; b2b_exp[6] = 9'h155;
        b2b_addr[7] = 17'h00000; b2b_exp[7] = 9'h1A5;

        // Reset state
        tick();
        tick();
        check_val("rst_dvalid", 32'(rd_dvalid), 32'd0);
        check_val("rst_data", 32'(rd_data), 32'd0);
        check_val("rst_sleep", 32'(bank_sleep), 32'd0);
        check_val("rst_gnt", 32'(rd_gnt), 32'd0);
        RSTN = 1'b1;
        tick();

        // 1: basic write then read with two-cycle latency
        do_write(17'h00000, 9'h1A5, "t1");
        do_read(17'h00000, 9'h1A5, "t1");
        tick();
        check_val("t1_dv_pulse", 32'(rd_dvalid), 32'd0);

        // 2: same-bank conflict, write wins, read retries
        do_write(17'h00020, 9'h0C3, "t2_pre");
        wr_en = 1'b1; wr_addr = 17'h00010; wr_data = 9'h033;
        rd_en = 1'b1; rd_addr = 17'h00020;
        #1;
        check_val("t2_wr_ready", 32'(wr_ready), 32'd1);
        check_val("t2_gnt_stall", 32'(rd_gnt), 32'd0);
        tick();
        wr_en = 1'b0;
        do_read(17'h00020, 9'h0C3, "t2");
        do_read(17'h00010, 9'h033, "t2b");

        // 3: different banks accepted together
        wr_en = 1'b1; wr_addr = 17'h08000; wr_data = 9'h07E;
        rd_en = 1'b1; rd_addr = 17'h00000;
        #1;
        check_val("t3_wr_ready", 32'(wr_ready), 32'd1);
        check_val("t3_gnt", 32'(rd_gnt), 32'd1);
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        tick();
        check_val("t3_dv", 32'(rd_dvalid), 32'd1);
        check_val("t3_data", 32'(rd_data), 32'h1A5);
        do_read(17'h08000, 9'h07E, "t3b");

        // 6: bank boundary and back-to-back reads
        do_write(17'h07FFF, 9'h0AA, "t6a");
        do_write(17'h08000, 9'h155, "t6b");
        do_read(17'h07FFF, 9'h0AA, "t6a");
        do_read(17'h08000, 9'h155, "t6b");
        for (int i = 0; i < 10; i++) begin
            if (i < 8) begin
                rd_en = 1'b1;
                rd_addr = b2b_addr[i];
            end else begin
                rd_en = 1'b0;
            end
            #1;
            if (i < 8) begin
                check_val($sformatf("b2b_gnt%0d", i), 32'(rd_gnt), 32'd1);
            end
            if (i >= 2) begin
                check_val($sformatf("b2b_dv%0d", i - 2), 32'(rd_dvalid), 32'd1);
                check_val($sformatf("b2b_data%0d", i - 2), 32'(rd_data), 32'(b2b_exp[i - 2]));
            end
            tick();
        end
        #1;
        check_val("b2b_dv_end", 32'(rd_dvalid), 32'd0);

        // 5: reset while a read is in flight
        tick();
        rd_en = 1'b1; rd_addr = 17'h08000;
        #1;
        check_val("t5_gnt", 32'(rd_gnt), 32'd1);
        tick();
        rd_en = 1'b0;
        RSTN = 1'b0;
        #1;
        check_val("t5_dv_in_rst", 32'(rd_dvalid), 32'd0);
        tick();
        RSTN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_val($sformatf("t5_dv%0d", i), 32'(rd_dvalid), 32'd0);
            check_val($sformatf("t5_data%0d", i), 32'(rd_data), 32'd0);
            tick();
        end

        // 4: auto-sleep and wake on demand
        sleep_en = 1'b1;
        repeat (10) tick();
        check_val("t4_awake10", 32'(bank_sleep), 32'd0);
        repeat (10) tick();
        check_val("t4_all_sleep", 32'(bank_sleep), 32'hF);
        wr_en = 1'b1; wr_addr = 17'h10000; wr_data = 9'h1FF;
        #1;
        check_val("t4_rdy_sleep", 32'(wr_ready), 32'd0);
        tick();
        check_val("t4_sleep_wake", 32'(bank_sleep), 32'hB);
        check_val("t4_rdy_wake0", 32'(wr_ready), 32'd0);
        for (int i = 1; i < 4; i++) begin
            tick();
            check_val($sformatf("t4_rdy_wake%0d", i), 32'(wr_ready), 32'd0);
        end
        tick();
        check_val("t4_rdy_active", 32'(wr_ready), 32'd1);
        tick();
        wr_en = 1'b0;
        sleep_en = 1'b0;
        tick();
        check_val("t4_wake_all", 32'(bank_sleep), 32'd0);
        repeat (6) tick();
        do_read(17'h10000, 9'h1FF, "t4_rd2");
        do_read(17'h00000, 9'h1A5, "t4_retain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
